typ_load_gather: RTL and testbench

//  Typed-memory load stage directly upstream of the typed compute unit (TypCompute).

---
 rtl/typ_mem_pkg.sv | 24 ++
 rtl/typ_gather_buf.sv | 57 +++++
 rtl/typ_load_gather.sv | 122 ++++++++++++
 tb/tb_typ_load_gather.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/typ_mem_pkg.sv
// Shared typing for the typed-memory load path and TypCompute operands.
package typ_mem_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_WORDS  = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned TAG_W      = $clog2(NUM_WORDS);
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_W     = NUM_WORDS * XLEN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Word read request payload
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
    } mem_req_t;

endpackage

// File: rtl/typ_gather_buf.sv
// Slot registers that collect out-of-order word responses into one packed value.
module typ_gather_buf
    import typ_mem_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [XLEN-1:0]   wr_data,
    output logic [DATA_W-1:0] data,
    output logic              all_rcvd_c,
    output logic              dup_hit_c
);

    logic [NUM_WORDS-1:0] mask_q, mask_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [NUM_WORDS-1:0] wr_onehot;
    logic                 accept;

    // Decode the write, reject duplicates (first data wins), compute next slots/mask
    always_comb begin
        wr_onehot         = '0;
        wr_onehot[wr_tag] = 1'b1;
        dup_hit_c         = wr_en & (|(mask_q & wr_onehot));
        accept            = wr_en & ~dup_hit_c;
        mask_d            = mask_q;
        data_d            = data_q;
        if (clear) begin
            mask_d = '0;
        end
        if (accept) begin
            mask_d = mask_d | wr_onehot;
        end
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            if (accept && wr_onehot[i]) begin
                data_d[i*XLEN +: XLEN] = wr_data;
            end
        end
        // Completion includes a response landing this cycle
        all_rcvd_c = &(mask_q | (accept ? wr_onehot : '0));
    end

    // Slot and mask registers
    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q <= '0;
            data_q <= '0;
        end else begin
            mask_q <= mask_d;
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/typ_load_gather.sv
// Typed load stage: issues NUM_WORDS word reads from a base address and gathers the
// (possibly reordered) responses into one packed operand for TypCompute.
module typ_load_gather
    import typ_mem_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [ADDR_W-1:0] io_in_addr,
    output logic              io_mem_req_valid,
    input  logic              io_mem_req_ready,
    output logic [ADDR_W-1:0] io_mem_req_addr,
    output logic [TAG_W-1:0]  io_mem_req_tag,
    input  logic              io_mem_resp_valid,
    input  logic [TAG_W-1:0]  io_mem_resp_tag,
    input  logic [XLEN-1:0]   io_mem_resp_data,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [DATA_W-1:0] io_out_data,
    output logic              io_err
);

    state_t            state_q, state_d;
    logic [TAG_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              err_q, err_d;

    logic              buf_clear;
    logic              buf_wr_en;
    logic              all_rcvd_c;
    logic              dup_hit_c;
    logic              resp_active;
    logic              tag_ok;
    logic              req_fire;
    logic              last_issue;
    mem_req_t          req;

    // Next state, issue counter, base latch and sticky error
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        base_d      = base_q;
        buf_clear   = 1'b0;
        resp_active = (state_q == ISSUE) || (state_q == WAIT);
        tag_ok      = ({1'b0, io_mem_resp_tag} < (TAG_W+1)'(NUM_WORDS));
        buf_wr_en   = io_mem_resp_valid & resp_active & tag_ok;
        req_fire    = (state_q == ISSUE) & io_mem_req_ready;
        last_issue  = (issue_cnt_q == TAG_W'(NUM_WORDS - 1));
        err_d       = err_q | (io_mem_resp_valid & (~resp_active | ~tag_ok | dup_hit_c));

        case (state_q)
            IDLE: begin
                if (io_in_valid) begin
                    base_d      = io_in_addr;
                    issue_cnt_d = '0;
                    buf_clear   = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (req_fire) begin
                    issue_cnt_d = issue_cnt_q + TAG_W'(1);
                    if (last_issue) begin
                        state_d = all_rcvd_c ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                if (all_rcvd_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (io_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            base_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            base_q      <= base_d;
            err_q       <= err_d;
        end
    end

    typ_gather_buf u_buf (
        .clock      (clock),
        .reset      (reset),
        .clear      (buf_clear),
        .wr_en      (buf_wr_en),
        .wr_tag     (io_mem_resp_tag),
        .wr_data    (io_mem_resp_data),
        .data       (io_out_data),
        .all_rcvd_c (all_rcvd_c),
        .dup_hit_c  (dup_hit_c)
    );

    // Outputs decoded from registered state; forced low while reset is held
    always_comb begin
        req.addr         = base_q + ADDR_W'(issue_cnt_q) * ADDR_W'(WORD_BYTES);
        req.tag          = issue_cnt_q;
        io_mem_req_addr  = req.addr;
        io_mem_req_tag   = req.tag;
        io_in_ready      = ~reset & (state_q == IDLE);
        io_mem_req_valid = ~reset & (state_q == ISSUE);
        io_out_valid     = ~reset & (state_q == DONE);
        io_err           = ~reset & err_q;
    end

endmodule

// File: tb/tb_typ_load_gather.sv
// Randomized bench for typ_load_gather with a queue-based memory model and scoreboard.
module tb_typ_load_gather;
    import typ_mem_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_in_valid;
    logic              io_in_ready;
    logic [ADDR_W-1:0] io_in_addr;
    logic              io_mem_req_valid;
    logic              io_mem_req_ready;
    logic [ADDR_W-1:0] io_mem_req_addr;
    logic [TAG_W-1:0]  io_mem_req_tag;
    logic              io_mem_resp_valid;
    logic [TAG_W-1:0]  io_mem_resp_tag;
    logic [XLEN-1:0]   io_mem_resp_data;
    logic              io_out_valid;
    logic              io_out_ready;
    logic [DATA_W-1:0] io_out_data;
    logic              io_err;

    typ_load_gather dut (
        .clock             (clock),
        .reset             (reset),
        .io_in_valid       (io_in_valid),
        .io_in_ready       (io_in_ready),
        .io_in_addr        (io_in_addr),
        .io_mem_req_valid  (io_mem_req_valid),
        .io_mem_req_ready  (io_mem_req_ready),
        .io_mem_req_addr   (io_mem_req_addr),
        .io_mem_req_tag    (io_mem_req_tag),
        .io_mem_resp_valid (io_mem_resp_valid),
        .io_mem_resp_tag   (io_mem_resp_tag),
        .io_mem_resp_data  (io_mem_resp_data),
        .io_out_valid      (io_out_valid),
        .io_out_ready      (io_out_ready),
        .io_out_data       (io_out_data),
        .io_err            (io_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  tag;
    } pend_t;

    pend_t pend[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    exp_err  = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents: each word holds its own address xor a per-transaction salt
    function automatic logic [127:0] exp_vec(input logic [31:0] base, input logic [31:0] salt);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = (base + 32'(4 * i)) ^ salt;
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_resp();
        io_mem_resp_valid = 1'b0;
        io_mem_resp_tag   = '0;
        io_mem_resp_data  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io_in_valid = 1'b0;
        io_mem_req_ready = 1'b0;
        io_out_ready = 1'b0;
        clear_resp();
        step();
        check("rst_in_ready", io_in_ready, 0);
        check("rst_req_valid", io_mem_req_valid, 0);
        check("rst_out_valid", io_out_valid, 0);
        check("rst_err", io_err, 0);
        reset = 1'b0;
        pend.delete();
        exp_err = 1'b0;
        step();
        check("post_rst_in_ready", io_in_ready, 1);
    endtask

    // rdy_mode: 0 always, 1 toggle, 2 random. resp_mode: 0 in order, 1 random, 2 order 3,1,0,2
    task automatic run_txn(input logic [31:0] base, input logic [31:0] salt, input int rdy_mode,
                           input int resp_mode, input int out_hold, input bit dup_inject,
                           input int exp_out_cycle);
        logic [127:0] exp;
        logic [31:0]  prev_addr;
        logic [1:0]   prev_tag;
        int issued, hold, out_first, order_idx, k;
        int order[4];
        bit done, prev_stall, rdy, dup_next, dup_done;
        bit in_rdy_bad, addr_bad, stab_bad, out_stab_bad;
        exp = exp_vec(base, salt);
        order = '{3, 1, 0, 2};
        issued = 0; hold = out_hold; out_first = -1; order_idx = 0;
        done = 0; prev_stall = 0; dup_next = 0; dup_done = 0;
        in_rdy_bad = 0; addr_bad = 0; stab_bad = 0; out_stab_bad = 0;
        prev_addr = '0; prev_tag = '0;
        if (dup_inject) exp_err = 1'b1;

        check("idle_in_ready", io_in_ready, 1);
        io_in_valid = 1'b1;
        io_in_addr  = base;
        step();
        io_in_valid = 1'b0;
        io_in_addr  = $urandom;

        for (int c = 1; c < 300 && !done; c++) begin
            clear_resp();
            if (dup_next) begin
                io_mem_resp_valid = 1'b1;
                io_mem_resp_tag   = 2'd1;
                io_mem_resp_data  = 32'hBAD;
                dup_next = 0;
                dup_done = 1;
            end else if (pend.size() > 0) begin
                k = -1;
                case (resp_mode)
                    0: k = 0;
                    1: if ($urandom_range(1, 0) == 1) k = int'($urandom_range(pend.size() - 1, 0));
                    default: begin
                        if (issued == 4 && order_idx < 4) begin
                            for (int j = 0; j < pend.size(); j++)
                                if (pend[j].tag == 2'(order[order_idx])) k = j;
                            order_idx++;
                        end
                    end
                endcase
                if (k >= 0) begin
                    io_mem_resp_valid = 1'b1;
                    io_mem_resp_tag   = pend[k].tag;
                    io_mem_resp_data  = pend[k].addr ^ salt;
                    if (dup_inject && !dup_done && pend[k].tag == 2'd1) dup_next = 1;
                    pend.delete(k);
                end
            end

            if (io_mem_req_valid) begin
                if (prev_stall && (io_mem_req_addr !== prev_addr || io_mem_req_tag !== prev_tag))
                    stab_bad = 1;
                case (rdy_mode)
                    0: rdy = 1'b1;
                    1: rdy = (c % 2 == 0);
                    default: rdy = 1'($urandom_range(1, 0));
                endcase
                io_mem_req_ready = rdy;
                if (rdy) begin
                    if (issued >= 4 || io_mem_req_addr !== base + 32'(4 * issued) ||
                        io_mem_req_tag !== 2'(issued))
                        addr_bad = 1;
                    pend.push_back('{io_mem_req_addr, io_mem_req_tag});
                    issued++;
                end
                prev_stall = !rdy;
                prev_addr  = io_mem_req_addr;
                prev_tag   = io_mem_req_tag;
            end else begin
                io_mem_req_ready = 1'($urandom_range(1, 0));
                prev_stall = 0;
            end

            if (io_in_ready) in_rdy_bad = 1;
            if (io_out_valid) begin
                if (out_first < 0) begin
                    out_first = c;
                    check("out_data", io_out_data, exp);
                end else if (io_out_data !== exp) begin
                    out_stab_bad = 1;
                end
                if (hold > 0) begin
                    io_out_ready = 1'b0;
                    hold--;
                end else begin
                    io_out_ready = 1'b1;
                    done = 1;
                end
            end else begin
                io_out_ready = 1'($urandom_range(1, 0));
            end
            step();
        end

        io_out_ready = 1'b0;
        io_mem_req_ready = 1'b0;
        clear_resp();
        check("completed", done, 1);
        check("after_in_ready", io_in_ready, 1);
        check("after_out_valid", io_out_valid, 0);
        check("issued_count", issued, 4);
        check("req_addr_tag", addr_bad, 0);
        check("req_stable", stab_bad, 0);
        check("in_ready_busy", in_rdy_bad, 0);
        check("out_stable", out_stab_bad, 0);
        check("pending_empty", pend.size(), 0);
        check("err", io_err, exp_err);
        if (exp_out_cycle > 0) check("out_latency", out_first, exp_out_cycle);
        pend.delete();
    endtask

    initial begin
        io_in_addr = '0;
        do_reset();

        // Basic zero-wait, in-order case with exact latency
        run_txn(32'h100, 32'h0, 0, 0, 0, 0, 6);
        // Reordered responses
        run_txn(32'h100, 32'h0, 0, 2, 0, 0, 0);
        // Back-pressure on both request and output sides
        run_txn(32'h4000, 32'h5A5A_0000, 1, 0, 5, 0, 0);
        // Address wrap
        run_txn(32'hFFFF_FFF8, 32'h0, 0, 0, 0, 0, 6);

        // Duplicate tag 1 keeps the first data and flags an error
        run_txn(32'h800, 32'h1234_0000, 0, 0, 0, 1, 0);
        do_reset();
        // Response while idle flags an error that stays set
        io_mem_resp_valid = 1'b1;
        io_mem_resp_tag   = 2'd2;
        io_mem_resp_data  = 32'h55;
        step();
        clear_resp();
        check("idle_resp_err", io_err, 1);
        exp_err = 1'b1;
        run_txn(32'h900, 32'h0, 2, 1, 1, 0, 0);

        // Reset in WAIT after two responses
        io_in_valid = 1'b1;
        io_in_addr  = 32'h300;
        step();
        io_in_valid = 1'b0;
        io_mem_req_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            clear_resp();
            if (c == 2 || c == 3) begin
                io_mem_resp_valid = 1'b1;
                io_mem_resp_tag   = 2'(c - 2);
                io_mem_resp_data  = 32'h300 + 32'(4 * (c - 2));
            end
            if (c == 5) begin
                check("wait_req_valid", io_mem_req_valid, 0);
                check("wait_out_valid", io_out_valid, 0);
            end else begin
                step();
            end
        end
        clear_resp();
        do_reset();
        run_txn(32'h200, 32'h0, 0, 0, 0, 0, 6);

        // Randomized traffic
        for (int t = 0; t < 25; t++) begin
            run_txn($urandom, $urandom, 2, 1, int'($urandom_range(3, 0)), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
